// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE     = 3'd1,
        REDIRECT = 3'd2,
        RET      = 3'd3,
        FAULT    = 3'd4
    } trap_state_t;

    typedef enum logic [1:0] {
        PC_SEQ   = 2'd0,
        PC_MTVEC = 2'd1,
        PC_MEPC  = 2'd2
    } pc_sel_t;

    localparam logic [31:0] IRQ_MTIMER_CAUSE   = 32'h8000_0007;

    localparam logic [31:0] EXC_ILLEGAL        = 32'd2;
    localparam logic [31:0] EXC_BREAK          = 32'd3;
    localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] EXC_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] EXC_ECALL_M        = 32'd11;

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry / MRET return sequencer between controller, CSR unit and PC mux.
// Optional double-fault detection is enabled with `define TRAP_SEQ_DOUBLE_FAULT_EN.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] IRQ_CAUSE = IRQ_MTIMER_CAUSE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            instr_boundary_i,
    input  logic            irq_pending_i,
    input  logic            mret_i,
    output logic            trap_enter_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_tval_o,
    output logic            mie_clear_o,
    output logic            mie_restore_o,
    output logic [1:0]      pc_sel_o,
    output logic            stall_o,
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
    output logic            double_fault_o,
`endif
    output logic            busy_o
);

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~(XLEN'(3));

    trap_state_t state;

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
    logic in_handler;
`endif

    // Outputs are registered on the transition into each state, so a request
    // seen in IDLE at cycle N shows up as the SAVE strobes at cycle N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            trap_enter_o  <= 1'b0;
            trap_pc_o     <= '0;
            trap_cause_o  <= '0;
            trap_tval_o   <= '0;
            mie_clear_o   <= 1'b0;
            mie_restore_o <= 1'b0;
            pc_sel_o      <= PC_SEQ;
            stall_o       <= 1'b0;
            busy_o        <= 1'b0;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
            double_fault_o <= 1'b0;
            in_handler     <= 1'b0;
`endif
        end else begin
            trap_enter_o  <= 1'b0;
            mie_clear_o   <= 1'b0;
            mie_restore_o <= 1'b0;
            pc_sel_o      <= PC_SEQ;
            stall_o       <= 1'b0;
            busy_o        <= 1'b0;

            case (state)
                IDLE: begin
                    if (exc_valid_i) begin
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
                        if (in_handler) begin
                            state          <= FAULT;
                            stall_o        <= 1'b1;
                            busy_o         <= 1'b1;
                            double_fault_o <= 1'b1;
                        end else begin
`endif
                            state        <= SAVE;
                            trap_pc_o    <= pc_i & PC_ALIGN_MASK;
                            trap_cause_o <= exc_cause_i;
                            trap_tval_o  <= exc_tval_i;
                            trap_enter_o <= 1'b1;
                            mie_clear_o  <= 1'b1;
                            stall_o      <= 1'b1;
                            busy_o       <= 1'b1;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
                        end
`endif
                    end else if (irq_pending_i && instr_boundary_i) begin
                        state        <= SAVE;
                        trap_pc_o    <= next_pc_i & PC_ALIGN_MASK;
                        trap_cause_o <= IRQ_CAUSE;
                        trap_tval_o  <= '0;
                        trap_enter_o <= 1'b1;
                        mie_clear_o  <= 1'b1;
                        stall_o      <= 1'b1;
                        busy_o       <= 1'b1;
                    end else if (mret_i) begin
                        state         <= RET;
                        mie_restore_o <= 1'b1;
                        pc_sel_o      <= PC_MEPC;
                        stall_o       <= 1'b1;
                        busy_o        <= 1'b1;
                    end
                end

                SAVE: begin
                    state    <= REDIRECT;
                    pc_sel_o <= PC_MTVEC;
                    stall_o  <= 1'b1;
                    busy_o   <= 1'b1;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
                    in_handler <= 1'b1;
`endif
                end

                REDIRECT: begin
                    state <= IDLE;
                end

                RET: begin
                    state <= IDLE;
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
                    in_handler <= 1'b0;
`endif
                end

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
                // Terminal until reset: the core is frozen with no further strobes.
                FAULT: begin
                    state          <= FAULT;
                    stall_o        <= 1'b1;
                    busy_o         <= 1'b1;
                    double_fault_o <= 1'b1;
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Sequences trap entry and MRET return around the machine-mode CSR unit.
- Arbitrates between synchronous exceptions from the main controller and the machine-timer interrupt.
- Generates the one-cycle CSR capture strobe (mepc/mcause/mtval), the MIE save/restore pulses and the PC-redirect select, and stalls the pipeline while a trap is in flight.
- Sits between the controller, the CSR unit and the PC mux.

Parameters:
- XLEN, 32, datapath/CSR width
- IRQ_CAUSE, 32'h8000_0007, mcause value for the machine-timer interrupt

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- exc_valid_i  in  1  controller reports a synchronous exception for the current instruction
- exc_cause_i  in  XLEN  exception cause code (bit 31 = 0)
- exc_tval_i  in  XLEN  trap value (faulting address or instruction)
- pc_i  in  XLEN  PC of the current instruction
- next_pc_i  in  XLEN  PC of the next instruction (interrupt return point)
- instr_boundary_i  in  1  current instruction is retiring this cycle
- irq_pending_i  in  1  timer interrupt pending and enabled (CSR unit mtime_exc_o)
- mret_i  in  1  current instruction is MRET
- trap_enter_o  out  1  one-cycle strobe: CSR unit captures mepc/mcause/mtval
- trap_pc_o  out  XLEN  value for mepc
- trap_cause_o  out  XLEN  value for mcause
- trap_tval_o  out  XLEN  value for mtval
- mie_clear_o  out  1  pulse: MPIE<=MIE, MIE<=0
- mie_restore_o  out  1  pulse: MIE<=MPIE, MPIE<=1
- pc_sel_o  out  2  PC source: 0 sequential, 1 mtvec, 2 mepc
- stall_o  out  1  freeze fetch/retire
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM to IDLE.
  - All outputs 0; captured registers 0.
- States: IDLE, SAVE, REDIRECT, RET.
- IDLE priority, evaluated each cycle:
  1. exc_valid_i: latch pc_i, exc_cause_i, exc_tval_i; go to SAVE.
  2. Else irq_pending_i && instr_boundary_i: latch next_pc_i, IRQ_CAUSE, tval 0; go to SAVE.
  3. Else mret_i: go to RET.
  4. Else stay in IDLE.
- SAVE (1 cycle):
  - trap_enter_o=1, mie_clear_o=1, stall_o=1.
  - trap_* outputs driven from the latched registers.
  - Next state: REDIRECT.
- REDIRECT (1 cycle):
  - pc_sel_o=1, stall_o=1.
  - Next state: IDLE.
- RET (1 cycle):
  - mie_restore_o=1, pc_sel_o=2, stall_o=1.
  - Next state: IDLE.
- Latency:
  - Request at cycle N: trap_enter_o at N+1, mtvec redirect at N+2, IDLE at N+3.
  - MRET at cycle N: redirect at N+1, IDLE at N+2.
- trap_pc_o/cause/tval hold their latched values until the next capture; they are valid whenever trap_enter_o=1.
- Simultaneous events:
  - Exception beats interrupt, which beats MRET.
  - An exception on an MRET instruction takes the trap; no restore pulse.
- irq_pending_i without instr_boundary_i is not taken; it is re-evaluated every IDLE cycle.
- Requests outside IDLE are ignored. The controller is stalled and must re-present them; interrupts still pending are retaken.
- mie_clear_o is issued before the next IDLE evaluation, so the interrupt is not retaken back-to-back while MIE=0.
- Reset mid-sequence: immediate return to IDLE; no partial strobe completes.
- trap_pc_o[1:0] forced to 2'b00.

Optional Feature:
- Macro TRAP_SEQ_DOUBLE_FAULT_EN.
- With the macro defined:
  - Add state FAULT and register in_handler.
  - in_handler is set on SAVE and cleared on RET.
  - A synchronous exception arriving while in_handler=1 goes to FAULT.
  - FAULT is terminal until reset: stall_o=1, output double_fault_o=1, no strobes.
- Without the macro:
  - Nested exceptions trap normally (mepc overwritten).
  - Neither in_handler nor double_fault_o exists.

Decomposition:
- Shared package gets:
  - trap_state_t enum (IDLE, SAVE, REDIRECT, RET, FAULT)
  - pc_sel_t enum (PC_SEQ=0, PC_MTVEC=1, PC_MEPC=2)
  - constant IRQ_MTIMER_CAUSE = 32'h8000_0007
  - exception cause constants: EXC_ILLEGAL=2, EXC_BREAK=3, EXC_ECALL_M=11, EXC_LOAD_MISALIGN=4, EXC_STORE_MISALIGN=6
- No sub-module: a single FSM plus capture registers.

Test Plan:
- Reset with rst_n low mid-SAVE: all outputs 0 immediately, IDLE on release, no trap_enter_o.
- exc_valid_i=1, cause=2, tval=0xDEADBEEF, pc_i=0x100 at N:
  - trap_enter_o, mie_clear_o at N+1 with trap_pc_o=0x100, cause=2, tval=0xDEADBEEF
  - pc_sel_o=1 at N+2
  - stall_o high N+1..N+2
- irq_pending_i=1, instr_boundary_i=0 for 3 cycles, then boundary=1 with next_pc_i=0x204:
  - no strobe before the boundary
  - then trap_cause_o=0x8000_0007, trap_pc_o=0x204
- exc_valid_i, irq_pending_i, instr_boundary_i and mret_i all 1 in the same cycle: exception cause latched; no mie_restore_o.
- mret_i=1 in IDLE: mie_restore_o and pc_sel_o=2 for exactly one cycle, then IDLE with pc_sel_o=0.
- With TRAP_SEQ_DOUBLE_FAULT_EN: exception, then a second exception before MRET: FAULT with double_fault_o=1 and stall held until reset. Without the macro, the second trap_enter_o fires with the new pc.
